// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register file.
//   resp_t       : AXI response encoding
//   PROT_W       : width of the (ignored) AxPROT fields
//   strb_merge() : byte-lane merge of new data into an old word (up to 64 bits)
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int unsigned PROT_W = 3;

    // Bytes whose strobe bit is set take the new value; the rest keep the old one.
    function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] merged;
        merged = old_val;
        for (int unsigned b = 0; b < 8; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle between an interconnect (master) and the register file (slave).
//   AW/W/B : write address, write data, write response channels
//   AR/R   : read address, read data channels
interface axi_lite_regfile_if #(
    parameter int unsigned ALEN = 32,
    parameter int unsigned DLEN = 32
) ();
    import axi_lite_pkg::*;

    localparam int unsigned SLEN = DLEN / 8;

    logic              awvalid;
    logic              awready;
    logic [ALEN-1:0]   awaddr;
    logic [PROT_W-1:0] awprot;
    logic              wvalid;
    logic              wready;
    logic [DLEN-1:0]   wdata;
    logic [SLEN-1:0]   wstrb;
    logic              bvalid;
    logic              bready;
    resp_t             bresp;
    logic              arvalid;
    logic              arready;
    logic [ALEN-1:0]   araddr;
    logic [PROT_W-1:0] arprot;
    logic              rvalid;
    logic              rready;
    logic [DLEN-1:0]   rdata;
    resp_t             rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi_lite_wr_join.sv
// Joins the AW and W channels: each is captured into its own holding buffer,
// in any order and with any gap, and a commit strobe fires once both are held
// and no write response is outstanding.
//   i_aclk, i_areset     : clock, synchronous active-high reset
//   i_awvalid/o_awready  : write address handshake, i_awaddr payload
//   i_wvalid/o_wready    : write data handshake, i_wdata/i_wstrb payload
//   i_bvalid             : write response pending (blocks commit)
//   o_commit             : one-cycle commit strobe
//   o_addr/o_data/o_strb : held write address, data and strobes
module axi_lite_wr_join #(
    parameter int unsigned ALEN = 32,
    parameter int unsigned DLEN = 32,
    parameter int unsigned SLEN = DLEN / 8
) (
    input  logic            i_aclk,
    input  logic            i_areset,
    input  logic            i_awvalid,
    input  logic [ALEN-1:0] i_awaddr,
    output logic            o_awready,
    input  logic            i_wvalid,
    input  logic [DLEN-1:0] i_wdata,
    input  logic [SLEN-1:0] i_wstrb,
    output logic            o_wready,
    input  logic            i_bvalid,
    output logic            o_commit,
    output logic [ALEN-1:0] o_addr,
    output logic [DLEN-1:0] o_data,
    output logic [SLEN-1:0] o_strb
);

    logic            r_aw_held;
    logic            r_w_held;
    logic [ALEN-1:0] r_addr;
    logic [DLEN-1:0] r_data;
    logic [SLEN-1:0] r_strb;

    assign o_awready = !r_aw_held;
    assign o_wready  = !r_w_held;
    // Gated by reset so a write landing in a reset cycle is dropped cleanly.
    assign o_commit  = r_aw_held && r_w_held && !i_bvalid && !i_areset;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_strb    = r_strb;

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= '0;
        end else if (o_commit) begin
            // Both buffers are full here, so no new handshake can coincide.
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else begin
            if (i_awvalid && o_awready) begin
                r_aw_held <= 1'b1;
                r_addr    <= i_awaddr;
            end
            if (i_wvalid && o_wready) begin
                r_w_held <= 1'b1;
                r_data   <= i_wdata;
                r_strb   <= i_wstrb;
            end
        end
    end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave exposing NREGS memory-mapped registers. Each register is
// software read/write or, when its RO_MASK bit is set, hardware-driven read-only.
//   i_aclk, i_areset : clock, synchronous active-high reset
//   bus              : AXI4-Lite slave bundle
//   o_reg_q          : RW register contents, register i at [i*DLEN +: DLEN]
//   i_hw_rd_data     : read values for RO registers, same packing
//   o_reg_wr_pulse   : one-cycle pulse per register on a successful write
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int unsigned     ALEN    = 32,
    parameter int unsigned     DLEN    = 32,
    parameter int unsigned     SLEN    = DLEN / 8,
    parameter int unsigned     NREGS   = 16,
    parameter logic [NREGS-1:0] RO_MASK = '0,
    parameter logic [DLEN-1:0]  RST_VAL = '0
) (
    input  logic                  i_aclk,
    input  logic                  i_areset,
    axi_lite_regfile_if.slave     bus,
    output logic [NREGS*DLEN-1:0] o_reg_q,
    input  logic [NREGS*DLEN-1:0] i_hw_rd_data,
    output logic [NREGS-1:0]      o_reg_wr_pulse
);

    localparam int unsigned AW_LSB = $clog2(SLEN);
    localparam int unsigned IDXW   = ALEN - AW_LSB;

    logic [DLEN-1:0] r_regs [NREGS];
    logic            r_bvalid;
    resp_t           r_bresp;
    logic            r_rvalid;
    logic [DLEN-1:0] r_rdata;
    resp_t           r_rresp;

    logic            w_commit;
    logic [ALEN-1:0] w_waddr;
    logic [DLEN-1:0] w_wdata;
    logic [SLEN-1:0] w_wstrb;
    logic [IDXW-1:0] w_widx;
    logic [IDXW-1:0] w_ridx;
    resp_t           w_wresp;
    resp_t           w_rresp;
    logic [DLEN-1:0] w_rdata;
    logic            w_wr_ok;
    logic            w_ar_hs;
    logic            w_unused_bits;

    // Out-of-range index -> DECERR; write to a read-only register -> SLVERR.
    function automatic resp_t decode(input logic [IDXW-1:0] idx, input logic is_wr);
        resp_t r;
        r = DECERR;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (idx == IDXW'(i)) begin
                r = (is_wr && RO_MASK[i]) ? SLVERR : OKAY;
            end
        end
        return r;
    endfunction

    axi_lite_wr_join #(
        .ALEN (ALEN),
        .DLEN (DLEN),
        .SLEN (SLEN)
    ) u_wr_join (
        .i_aclk    (i_aclk),
        .i_areset  (i_areset),
        .i_awvalid (bus.awvalid),
        .i_awaddr  (bus.awaddr),
        .o_awready (bus.awready),
        .i_wvalid  (bus.wvalid),
        .i_wdata   (bus.wdata),
        .i_wstrb   (bus.wstrb),
        .o_wready  (bus.wready),
        .i_bvalid  (r_bvalid),
        .o_commit  (w_commit),
        .o_addr    (w_waddr),
        .o_data    (w_wdata),
        .o_strb    (w_wstrb)
    );

    assign w_widx  = w_waddr[ALEN-1:AW_LSB];
    assign w_ridx  = bus.araddr[ALEN-1:AW_LSB];
    assign w_wresp = decode(w_widx, 1'b1);
    assign w_wr_ok = w_commit && (w_wresp == OKAY);
    assign w_ar_hs = bus.arvalid && !r_rvalid;

    // prot and sub-word address bits carry no meaning for this block.
    assign w_unused_bits = ^{bus.awprot, bus.arprot, w_waddr[AW_LSB-1:0],
                             bus.araddr[AW_LSB-1:0]};

    // Read data is taken from the pre-commit register value (old value).
    always_comb begin
        w_rresp = decode(w_ridx, 1'b0);
        w_rdata = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (w_ridx == IDXW'(i)) begin
                w_rdata = RO_MASK[i] ? i_hw_rd_data[i*DLEN +: DLEN] : r_regs[i];
            end
        end
    end

    always_comb begin
        o_reg_q        = '0;
        o_reg_wr_pulse = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            o_reg_q[i*DLEN +: DLEN] = r_regs[i];
            o_reg_wr_pulse[i]       = w_wr_ok && (w_widx == IDXW'(i));
        end
    end

    always_ff @(posedge i_aclk) begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (i_areset) begin
                r_regs[i] <= RST_VAL;
            end else if (w_wr_ok && (w_widx == IDXW'(i))) begin
                r_regs[i] <= DLEN'(strb_merge(64'(r_regs[i]), 64'(w_wdata), 8'(w_wstrb)));
            end
        end
    end

    // Write response: loaded on commit, held until bready.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_bvalid <= 1'b0;
            r_bresp  <= OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wresp;
        end else if (r_bvalid && bus.bready) begin
            r_bvalid <= 1'b0;
        end
    end

    // Read response: loaded on AR handshake, held until rready.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
            r_rresp  <= w_rresp;
        end else if (r_rvalid && bus.rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign bus.bvalid  = r_bvalid;
    assign bus.bresp   = r_bresp;
    assign bus.arready = !r_rvalid;
    assign bus.rvalid  = r_rvalid;
    assign bus.rdata   = r_rdata;
    assign bus.rresp   = r_rresp;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: hand-written latency/back-pressure/reset
// sequences plus a table of single write/read transactions.
module tb_axi_lite_regfile;
    import axi_lite_pkg::*;

    localparam int unsigned NREGS = 16;
    localparam int unsigned DLEN  = 32;

    logic                  clk;
    logic                  areset;
    logic [NREGS*DLEN-1:0] reg_q;
    logic [NREGS*DLEN-1:0] hw_rd_data;
    logic [NREGS-1:0]      pulse;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_regs [NREGS];

    axi_lite_regfile_if #(.ALEN(32), .DLEN(32)) bus ();

    axi_lite_regfile #(
        .ALEN    (32),
        .DLEN    (32),
        .NREGS   (NREGS),
        .RO_MASK (16'h0008),
        .RST_VAL (32'h0)
    ) dut (
        .i_aclk         (clk),
        .i_areset       (areset),
        .bus            (bus),
        .o_reg_q        (reg_q),
        .i_hw_rd_data   (hw_rd_data),
        .o_reg_wr_pulse (pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [15:0] exp_pulse;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [511:0] model_q();
        logic [511:0] v;
        for (int i = 0; i < NREGS; i++) v[i*32 +: 32] = exp_regs[i];
        return v;
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = o;
        if (s[0]) r[7:0]   = n[7:0];
        if (s[1]) r[15:8]  = n[15:8];
        if (s[2]) r[23:16] = n[23:16];
        if (s[3]) r[31:24] = n[31:24];
        return r;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [15:0] pseen, output bit ok);
        bit aw_done = 0;
        bit w_done = 0;
        bus.awvalid = 1'b1; bus.awaddr = a;
        bus.wvalid = 1'b1;  bus.wdata = d; bus.wstrb = s;
        resp = 2'b00; pseen = '0; ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.wvalid && bus.wready) w_done = 1;
            pseen |= pulse;
            if (bus.bvalid && bus.bready) begin
                resp = bus.bresp;
                ok = 1;
            end
            tick();
            if (aw_done) bus.awvalid = 1'b0;
            if (w_done) bus.wvalid = 1'b0;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output bit ok);
        bit ar_done = 0;
        bus.arvalid = 1'b1; bus.araddr = a;
        d = '0; resp = 2'b00; ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (bus.arvalid && bus.arready) ar_done = 1;
            if (bus.rvalid && bus.rready) begin
                d = bus.rdata;
                resp = bus.rresp;
                ok = 1;
            end
            tick();
            if (ar_done) bus.arvalid = 1'b0;
        end
        bus.arvalid = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [15:0] pseen;
        bit          ok;

        vecs[0]  = '{1'b0, 32'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0};
        vecs[1]  = '{1'b1, 32'h08, 32'h00001100, 4'h2, 2'b00, 32'h0,        16'h0004};
        vecs[2]  = '{1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'h000011AA, 16'h0};
        vecs[3]  = '{1'b1, 32'h40, 32'h0BADF00D, 4'hF, 2'b11, 32'h0,        16'h0};
        vecs[4]  = '{1'b0, 32'h40, 32'h0,        4'h0, 2'b11, 32'h0,        16'h0};
        vecs[5]  = '{1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,        16'h0};
        vecs[6]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'h12345678, 16'h0};
        vecs[7]  = '{1'b1, 32'h07, 32'h00000055, 4'h0, 2'b00, 32'h0,        16'h0002};
        vecs[8]  = '{1'b0, 32'h05, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0};
        vecs[9]  = '{1'b1, 32'h3C, 32'hA5A5A5A5, 4'hC, 2'b00, 32'h0,        16'h8000};
        vecs[10] = '{1'b0, 32'h3E, 32'h0,        4'h0, 2'b00, 32'hA5A50000, 16'h0};

        for (int i = 0; i < NREGS; i++) begin
            exp_regs[i] = 32'h0;
            hw_rd_data[i*32 +: 32] = 32'hCAFE0000 + 32'(i);
        end
        hw_rd_data[3*32 +: 32] = 32'h12345678;

        areset = 1'b1;
        bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
        bus.wvalid = 0;  bus.wdata = 0;  bus.wstrb = 0;
        bus.bready = 1;
        bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0;
        bus.rready = 1;
        tick(); tick();
        chk("rst_awready", bus.awready, 1);
        chk("rst_wready", bus.wready, 1);
        chk("rst_arready", bus.arready, 1);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_bresp_rresp_rdata", {bus.bresp, bus.rresp, bus.rdata}, 0);
        chk("rst_reg_q", reg_q, model_q());
        chk("rst_pulse", pulse, 0);
        areset = 1'b0;
        tick();

        // AW+W same cycle: pulse in cycle 1, bvalid and reg_q update in cycle 2.
        bus.awvalid = 1; bus.awaddr = 32'h04;
        bus.wvalid = 1;  bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
        tick();
        bus.awvalid = 0; bus.wvalid = 0;
        chk("lat_c1_pulse", pulse, 16'h0002);
        chk("lat_c1_bvalid", bus.bvalid, 0);
        chk("lat_c1_reg_q", reg_q, model_q());
        tick();
        exp_regs[1] = 32'hDEADBEEF;
        chk("lat_c2_bvalid", bus.bvalid, 1);
        chk("lat_c2_bresp", bus.bresp, 2'b00);
        chk("lat_c2_reg_q", reg_q, model_q());
        chk("lat_c2_pulse", pulse, 0);
        tick();
        chk("lat_c3_bvalid", bus.bvalid, 0);

        // W three cycles ahead of AW.
        bus.wvalid = 1; bus.wdata = 32'h000000AA; bus.wstrb = 4'h1;
        tick();
        bus.wvalid = 0;
        for (int c = 0; c < 3; c++) begin
            chk("wfirst_wready_low", bus.wready, 0);
            chk("wfirst_no_pulse", pulse, 0);
            if (c == 2) begin
                bus.awvalid = 1; bus.awaddr = 32'h08;
            end
            tick();
        end
        bus.awvalid = 0;
        chk("wfirst_commit_pulse", pulse, 16'h0004);
        chk("wfirst_reg_before", reg_q, model_q());
        tick();
        exp_regs[2] = 32'h000000AA;
        chk("wfirst_bvalid", bus.bvalid, 1);
        chk("wfirst_reg_after", reg_q, model_q());
        chk("wfirst_wready_back", bus.wready, 1);
        tick();

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pseen, ok);
                chk($sformatf("vec%0d_wr_done", i), ok, 1);
                chk($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
                chk($sformatf("vec%0d_pulse", i), pseen, vecs[i].exp_pulse);
                if (vecs[i].exp_resp == 2'b00) begin
                    exp_regs[vecs[i].addr[5:2]] = apply_strb(exp_regs[vecs[i].addr[5:2]],
                                                             vecs[i].data, vecs[i].strb);
                end
                chk($sformatf("vec%0d_reg_q", i), reg_q, model_q());
            end else begin
                do_read(vecs[i].addr, rd, resp, ok);
                chk($sformatf("vec%0d_rd_done", i), ok, 1);
                chk($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            end
        end

        // B back-pressure: second write stays held until the first response drains.
        bus.bready = 0;
        bus.awvalid = 1; bus.awaddr = 32'h10;
        bus.wvalid = 1;  bus.wdata = 32'h1; bus.wstrb = 4'hF;
        tick();
        bus.awvalid = 0; bus.wvalid = 0;
        chk("bp_first_pulse", pulse, 16'h0010);
        tick();
        exp_regs[4] = 32'h1;
        chk("bp_first_bvalid", bus.bvalid, 1);
        bus.awvalid = 1; bus.awaddr = 32'h14;
        bus.wvalid = 1;  bus.wdata = 32'h2;
        tick();
        bus.awvalid = 0; bus.wvalid = 0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_bvalid", bus.bvalid, 1);
            chk("bp_hold_bresp", bus.bresp, 2'b00);
            chk("bp_hold_readies", {bus.awready, bus.wready}, 2'b00);
            chk("bp_hold_pulse", pulse, 0);
            chk("bp_hold_reg_q", reg_q, model_q());
            tick();
        end
        bus.bready = 1;
        tick();
        chk("bp_drain_bvalid", bus.bvalid, 0);
        chk("bp_second_pulse", pulse, 16'h0020);
        tick();
        exp_regs[5] = 32'h2;
        chk("bp_second_bvalid", bus.bvalid, 1);
        chk("bp_second_reg_q", reg_q, model_q());
        tick();
        chk("bp_second_drained", bus.bvalid, 0);

        // R back-pressure: arready low while rvalid is held.
        bus.rready = 0;
        bus.arvalid = 1; bus.araddr = 32'h04;
        tick();
        bus.araddr = 32'h10;
        for (int c = 0; c < 4; c++) begin
            chk("rbp_rvalid", bus.rvalid, 1);
            chk("rbp_rdata", bus.rdata, 32'hDEADBEEF);
            chk("rbp_arready", bus.arready, 0);
            tick();
        end
        bus.rready = 1;
        tick();
        chk("rbp_drain_rvalid", bus.rvalid, 0);
        chk("rbp_drain_arready", bus.arready, 1);
        tick();
        bus.arvalid = 0;
        chk("rbp_second_rvalid", bus.rvalid, 1);
        chk("rbp_second_rdata", bus.rdata, 32'h1);
        tick();
        chk("rbp_second_drained", bus.rvalid, 0);

        // Reset mid-transaction: held AW, pending R and an in-flight commit are dropped.
        bus.rready = 0;
        bus.awvalid = 1; bus.awaddr = 32'h00;
        bus.arvalid = 1; bus.araddr = 32'h04;
        tick();
        bus.awvalid = 0; bus.arvalid = 0;
        chk("mrst_aw_held", bus.awready, 0);
        chk("mrst_rvalid", bus.rvalid, 1);
        bus.wvalid = 1; bus.wdata = 32'h77; bus.wstrb = 4'hF;
        tick();
        bus.wvalid = 0;
        chk("mrst_commit_pulse", pulse, 16'h0001);
        areset = 1;
        tick();
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 32'h0;
        chk("mrst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        chk("mrst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        chk("mrst_rdata", bus.rdata, 0);
        chk("mrst_reg_q", reg_q, model_q());
        areset = 0;
        bus.rready = 1;
        tick();
        chk("mrst_after_reg_q", reg_q, model_q());
        chk("mrst_after_bvalid", bus.bvalid, 0);
        do_read(32'h04, rd, resp, ok);
        chk("mrst_read_done", ok, 1);
        chk("mrst_read_rdata", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
- Parametrised AXI4-Lite slave implementing a bank of NREGS memory-mapped registers.
- Each register is either software read/write or hardware-driven read-only.
- Adds features absent from a plain bus interface: independent AW/W acceptance in either order, byte strobes, decode/slave error responses, and per-register write pulses.
- Sits between the AXI-Lite interconnect and core control/status logic.

Parameters:
- ALEN, 32, address width.
- DLEN, 32, data width; 32 or 64 only.
- SLEN, DLEN/8, strobe width.
- NREGS, 16, number of registers; at least 1.
- RO_MASK, NREGS'b0, bit i set means register i is hardware-driven read-only.
- RST_VAL, DLEN'b0, reset value of every RW register.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- awvalid/awready  in/out  1  write address handshake
- awaddr  in  ALEN  write address
- awprot  in  3  ignored
- wvalid/wready  in/out  1  write data handshake
- wdata  in  DLEN  write data
- wstrb  in  SLEN  write byte strobes
- bvalid/bready  out/in  1  write response handshake
- bresp  out  2  write response
- arvalid/arready  in/out  1  read address handshake
- araddr  in  ALEN  read address
- arprot  in  3  ignored
- rvalid/rready  out/in  1  read data handshake
- rdata  out  DLEN  read data
- rresp  out  2  read response
- reg_q  out  NREGS*DLEN  current RW register contents; register i at [i*DLEN +: DLEN]
- hw_rd_data  in  NREGS*DLEN  values returned for RO registers
- reg_wr_pulse  out  NREGS  one-cycle pulse when register i is written

Behaviour:
- One clock, aclk. Reset is synchronous and active-high (areset). All state updates on the rising edge of aclk.
- Reset: awready, wready, arready = 1; bvalid, rvalid, reg_wr_pulse = 0; bresp, rresp, rdata = 0; RW registers = RST_VAL.
- Reset asserted mid-transaction discards held AW/W, pending B and pending R with no response; the register writes being committed that cycle are lost.
- Decode: index = addr[ALEN-1:log2(SLEN)], so low address bits are ignored.
  - index >= NREGS: DECERR (2'b11).
  - Write to an index set in RO_MASK: SLVERR (2'b10).
  - Otherwise: OKAY (2'b00).
- Write address/data join:
  - aw_held and w_held are flags with buffers; awready = !aw_held, wready = !w_held.
  - AW and W may arrive in the same cycle or in either order, with any gap between them.
  - Commit cycle is any cycle with aw_held && w_held && !bvalid.
  - On commit:
    - Register bytes with wstrb[k]=1 are updated, only if the decode result is OKAY.
    - reg_wr_pulse[index] is asserted for that one cycle, OKAY only.
    - bresp is loaded and both held flags clear.
    - bvalid rises next cycle.
  - Latency: AW and W accepted in cycle 0 give commit in cycle 1, bvalid in cycle 2, and reg_q updated from cycle 2.
  - bvalid holds, with bresp stable, until bready. A new commit is blocked while bvalid=1, which back-pressures AW/W.
  - wstrb = 0 with OKAY: no bytes change, reg_wr_pulse still fires, bresp OKAY.
- Read channel:
  - arready = !rvalid.
  - On AR handshake in cycle 0, rdata/rresp are registered and rvalid=1 from cycle 1.
  - RW register: rdata is the register value before any commit in that same cycle (old value).
  - RO register: rdata is hw_rd_data sampled at the handshake.
  - DECERR read: rdata = 0.
  - rvalid, rdata and rresp stay stable until rready. Peak throughput is 1 read per 2 cycles.
- Read and write channels are fully independent; neither blocks the other.
- prot inputs are ignored; EXOKAY (2'b01) is never returned.

Decomposition:
- Package axi_lite_pkg contains:
  - typedef enum logic [1:0] resp_t with values OKAY, EXOKAY, SLVERR, DECERR.
  - Localparam prot width = 3.
  - Function for byte-strobe merge: old, new, strb -> merged.
- Sub-module axi_lite_wr_join:
  - Contains the AW/W holding buffers, ready generation and the commit strobe.
  - Outputs the held addr/data/strb.
  - The top module does decode, registers and the B/R channels.

Test Plan:
- Reset, then AW+W same cycle to 0x04, data 0xDEADBEEF, wstrb 0xF -> bvalid in cycle 2, bresp 0, reg_wr_pulse[1] in cycle 1; read 0x04 -> rdata 0xDEADBEEF, rresp 0.
- W (0x000000AA, wstrb 0x1) sent 3 cycles before AW 0x08 -> wready low until commit; reg2 goes from 0x00000000 to 0x000000AA; an added write of 0x1100 with wstrb 0x2 gives 0x000011AA.
- Write and read to 0x40 with NREGS=16 -> bresp 2'b11, rresp 2'b11, rdata 0, no reg_q change, no pulse.
- RO_MASK bit 3 set, hw_rd_data[3] = 0x12345678: write 0x0C -> bresp SLVERR, no pulse; read 0x0C -> 0x12345678, OKAY.
- Hold bready=0 for 5 cycles after first response, then issue a second AW/W -> bvalid/bresp stable, awready/wready low after holding, second commit only after bready; same for rready=0 with arready low.
- Assert areset while AW held and rvalid=1 -> next cycle all readies 1, bvalid=rvalid=0, registers = RST_VAL.
